// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC register with a direct-mapped BTB and 2-bit counters.
// All outputs are combinational from the PC register, BTB state and imem_data_i.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] curr_pc_o,
  output logic [31:0] next_pc_o,
  output logic [31:0] instr_o,
  output logic        brn_pred_o
);

  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W   = 32 - BTB_IDX_W - 2;

  logic [31:0]          pc_q;
  logic [31:0]          pc_d;
  logic                 valid_q    [ENTRIES];
  logic [1:0]           ctr_q      [ENTRIES];
  logic [TAG_W-1:0]     tag_mem    [ENTRIES];
  logic [29:0]          target_mem [ENTRIES];

  logic [BTB_IDX_W-1:0] idx;
  logic [TAG_W-1:0]     tag;
  logic                 hit;
  logic                 pred;

  logic [BTB_IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0]     upd_tag;
  logic                 upd_hit;
  logic [1:0]           upd_ctr;
  logic                 wr_ctr;
  logic                 wr_entry;

  // Address bits below word alignment never reach any state.
  logic unused_low_bits;
  assign unused_low_bits = ^{redirect_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

  assign idx  = pc_q[BTB_IDX_W+1:2];
  assign tag  = pc_q[31:BTB_IDX_W+2];
  assign hit  = valid_q[idx] && (tag_mem[idx] == tag);
  assign pred = hit && ctr_q[idx][1];

  assign imem_addr_o = pc_q;
  assign curr_pc_o   = pc_q;
  assign next_pc_o   = pc_q + 32'd4;
  assign instr_o     = imem_data_i;
  assign brn_pred_o  = pred;

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect_i)   pc_d = {redirect_pc_i[31:2], 2'b00};
    else if (stall_i) pc_d = pc_q;
    else if (pred)    pc_d = {target_mem[idx], 2'b00};
  end

  assign upd_idx = upd_pc_i[BTB_IDX_W+1:2];
  assign upd_tag = upd_pc_i[31:BTB_IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_mem[upd_idx] == upd_tag);

  // A miss that resolves not-taken leaves the entry alone; a taken miss
  // evicts whatever occupied the slot and starts weakly taken.
  assign wr_ctr   = upd_valid_i && (upd_hit || upd_taken_i);
  assign wr_entry = upd_valid_i && upd_taken_i;

  always_comb begin
    upd_ctr = ctr_q[upd_idx];
    if (!upd_hit) begin
      upd_ctr = 2'b10;
    end else if (upd_taken_i) begin
      if (ctr_q[upd_idx] != 2'b11) upd_ctr = ctr_q[upd_idx] + 2'd1;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) upd_ctr = ctr_q[upd_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      pc_q <= pc_d;
      if (wr_ctr)   ctr_q[upd_idx]   <= upd_ctr;
      if (wr_entry) valid_q[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_entry) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= upd_target_i[31:2];
    end
  end

endmodule
